bbus_sink: RTL

Destination end of the CPU B-bus. Each cycle a destination select and load strobe decide where the value on `b_bus` goes: the A register, the B register, an external output port, or nowhere. The external port is a small FIFO with a valid/ready handshake, so the downstream consumer can stall without stalling the datapath. The block sits after the B-bus source mux and closes the loop: `b_reg` held here feeds the mux.

---
 rtl/bbus_pkg.sv | 15 +
 rtl/bbus_out_fifo.sv | 81 ++++++++
 rtl/bbus_sink.sv | 85 ++++++++
 3 files changed

// File: rtl/bbus_pkg.sv
// Shared definitions for the B-bus destination logic.
package bbus_pkg;

   // Default data width of the B-bus and the registers it loads.
   localparam int BUS_W_DEFAULT = 8;

   // Destination select encoding carried on d_sel.
   typedef enum logic [1:0] {
      DST_NONE = 2'b00,
      DST_A    = 2'b01,
      DST_B    = 2'b10,
      DST_EXT  = 2'b11
   } dsel_t;

endpackage : bbus_pkg

// File: rtl/bbus_out_fifo.sv
// Output FIFO for the external B-bus destination. The head is read straight
// from storage; a push into a full FIFO is accepted only if a pop frees a
// slot in the same cycle, otherwise it is dropped and reported on `drop`.
module bbus_out_fifo #(
   parameter int BUS_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [BUS_W-1:0] push_data,
   input  logic             pop,
   output logic [BUS_W-1:0] head,
   output logic             empty,
   output logic             full,
   output logic             drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [BUS_W-1:0] mem_q [DEPTH];
   logic [BUS_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign head  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy count.
   always_comb begin
      // NOTE: every signal gets a default before any condition so no path leaves it unassigned (no latch).
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop     = 1'b0;

      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      drop    = push && full && !do_pop;

      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         // NOTE: storage is cleared on reset so the stale head seen while empty is a defined 0.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule : bbus_out_fifo

// File: rtl/bbus_sink.sv
// Destination end of the B-bus: decodes d_sel/d_load into loads of the A and
// B registers or a push into the external output FIFO, and keeps a sticky
// overflow flag for pushes the FIFO had to drop.
module bbus_sink
   import bbus_pkg::*;
#(
   parameter int BUS_W = bbus_pkg::BUS_W_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BUS_W-1:0] b_bus,
   input  logic [1:0]       d_sel,
   input  logic             d_load,
   output logic [BUS_W-1:0] a_reg,
   output logic [BUS_W-1:0] b_reg,
   output logic [BUS_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             fifo_full,
   output logic             overflow,
   input  logic             clr_ovf
);

   dsel_t            dsel;
   logic             load_a;
   logic             load_b;
   logic             push_ext;
   logic             fifo_empty;
   logic             fifo_drop;
   logic [BUS_W-1:0] a_q, a_d;
   logic [BUS_W-1:0] b_q, b_d;
   logic             ovf_q, ovf_d;

   assign dsel     = dsel_t'(d_sel);
   assign load_a   = d_load && (dsel == DST_A);
   assign load_b   = d_load && (dsel == DST_B);
   assign push_ext = d_load && (dsel == DST_EXT);

   bbus_out_fifo #(
      .BUS_W (BUS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_ext),
      .push_data (b_bus),
      .pop       (out_ready),
      .head      (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .drop      (fifo_drop)
   );

   assign out_valid = !fifo_empty;
   assign a_reg     = a_q;
   assign b_reg     = b_q;
   assign overflow  = ovf_q;

   // Register loads and overflow flag; a drop in the same cycle beats clr_ovf.
   always_comb begin
      a_d   = load_a ? b_bus : a_q;
      b_d   = load_b ? b_bus : b_q;
      ovf_d = ovf_q;
      if (fifo_drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // A/B registers and sticky overflow with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         ovf_q <= ovf_d;
      end
   end

endmodule : bbus_sink
